// File: rtl/chop_mult_pipe_acc_if.sv
// Operand/result bundle of the pipelined chopped multiplier.
// The master side drives operands and controls, and the slave side returns products and the accumulator.
interface chop_mult_pipe_acc_if #(
    parameter int WIDTH  = 12,
    parameter int LEVELS = 2,
    parameter int MODE_W = 2
);
    localparam int NL = 1 << LEVELS;

    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 A_sign;
    logic                 B_sign;
    logic [MODE_W-1:0]    mode;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   P;
    logic                 acc_valid;
    logic [2*WIDTH-1:0]   ACC;
    logic [NL-1:0]        acc_ovf;

    modport master (
        output in_valid, A, B, A_sign, B_sign, mode, acc_en, acc_clr,
        input  out_valid, P, acc_valid, ACC, acc_ovf
    );
    modport slave (
        input  in_valid, A, B, A_sign, B_sign, mode, acc_en, acc_clr,
        output out_valid, P, acc_valid, ACC, acc_ovf
    );
endinterface

// File: rtl/chop_mult_pipe_acc.sv
// Pipelined split-precision multiplier: one WIDTH x WIDTH product or 2^L isolated lane products per cycle,
// with an optional lane-isolated accumulator that keeps a sticky overflow bit for each lane.
module chop_mult_lane #(
    parameter int W = 3
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           a_sign,
    input  logic           b_sign,
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] p,
    input  logic           sgn,
    output logic [2*W-1:0] prod,
    output logic [2*W-1:0] sum,
    output logic           ovf
);
    logic [2*W-1:0] ax, bx;
    logic           c;

    // The low 2W bits of the extended product are exact for every sign mix.
    assign ax   = a_sign ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    assign bx   = b_sign ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    assign prod = ax * bx;

    assign {c, sum} = {1'b0, acc} + {1'b0, p};
    assign ovf = sgn ? ((acc[2*W-1] == p[2*W-1]) && (sum[2*W-1] != acc[2*W-1])) : c;
endmodule

module chop_mult_pipe_acc #(
    parameter int WIDTH       = 12,
    parameter int LEVELS      = 2,
    parameter int PIPE_STAGES = 2,
    parameter int MODE_W      = 2
) (
    input  logic                clk,
    input  logic                reset,
    chop_mult_pipe_acc_if.slave bus
);
    localparam int NL = 1 << LEVELS;
    localparam int PW = 2 * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic              a_sign;
        logic              b_sign;
        logic [MODE_W-1:0] lvl;
        logic              acc_en;
        logic              acc_clr;
    } req_t;

    req_t                   req_in, req_mul;
    logic                   mul_vld;
    logic [PIPE_STAGES-1:0] vld_pipe;

    logic [PW-1:0]     p_q, acc_q;
    logic [NL-1:0]     ovf_q;
    logic              acc_vld_q;
    logic [MODE_W-1:0] p_lvl, last_lvl;
    logic              p_sgn, p_acc_en, p_acc_clr;

    logic [PW-1:0] prod_lvl [LEVELS+1];
    logic [PW-1:0] sum_lvl  [LEVELS+1];
    logic [NL-1:0] ovf_lvl  [LEVELS+1];
    logic [PW-1:0] prod_sel, sum_sel;
    logic [NL-1:0] ovf_sel;

    always_comb begin
        req_in.a       = bus.A;
        req_in.b       = bus.B;
        req_in.a_sign  = bus.A_sign;
        req_in.b_sign  = bus.B_sign;
        req_in.lvl     = (bus.mode > MODE_W'(LEVELS)) ? MODE_W'(LEVELS) : bus.mode;
        req_in.acc_en  = bus.acc_en;
        req_in.acc_clr = bus.acc_clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= bus.in_valid;
            for (int i = 1; i < PIPE_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Operands travel down the pipe, and the multiply feeds the final product register.
    if (PIPE_STAGES == 1) begin : g_nopipe
        assign req_mul = req_in;
        assign mul_vld = bus.in_valid;
    end else begin : g_pipe
        req_t req_pipe [PIPE_STAGES-1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_STAGES-1; i++) req_pipe[i] <= '0;
            end else begin
                req_pipe[0] <= req_in;
                for (int i = 1; i < PIPE_STAGES-1; i++) req_pipe[i] <= req_pipe[i-1];
            end
        end
        assign req_mul = req_pipe[PIPE_STAGES-2];
        assign mul_vld = vld_pipe[PIPE_STAGES-2];
    end

    // Every split level is built in parallel, and the item's own level picks the result.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int LW = WIDTH >> l;
        localparam int LN = 1 << l;
        logic [LN-1:0] ovf_l;
        for (genvar k = 0; k < LN; k++) begin : g_lane
            chop_mult_lane #(.W(LW)) u_lane (
                .a      (req_mul.a[k*LW +: LW]),
                .b      (req_mul.b[k*LW +: LW]),
                .a_sign (req_mul.a_sign),
                .b_sign (req_mul.b_sign),
                .acc    (acc_q[k*2*LW +: 2*LW]),
                .p      (p_q[k*2*LW +: 2*LW]),
                .sgn    (p_sgn),
                .prod   (prod_lvl[l][k*2*LW +: 2*LW]),
                .sum    (sum_lvl[l][k*2*LW +: 2*LW]),
                .ovf    (ovf_l[k])
            );
        end
        assign ovf_lvl[l] = NL'(ovf_l);
    end

    always_comb begin
        prod_sel = '0;
        sum_sel  = '0;
        ovf_sel  = '0;
        for (int l = 0; l <= LEVELS; l++) begin
            if (req_mul.lvl == MODE_W'(l)) prod_sel = prod_lvl[l];
            if (p_lvl == MODE_W'(l)) begin
                sum_sel = sum_lvl[l];
                ovf_sel = ovf_lvl[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            p_lvl     <= '0;
            p_sgn     <= 1'b0;
            p_acc_en  <= 1'b0;
            p_acc_clr <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= '0;
            acc_vld_q <= 1'b0;
            last_lvl  <= '0;
        end else begin
            if (mul_vld) begin
                p_q       <= prod_sel;
                p_lvl     <= req_mul.lvl;
                p_sgn     <= req_mul.a_sign | req_mul.b_sign;
                p_acc_en  <= req_mul.acc_en;
                p_acc_clr <= req_mul.acc_clr;
            end
            acc_vld_q <= vld_pipe[PIPE_STAGES-1] && p_acc_en;
            if (vld_pipe[PIPE_STAGES-1] && p_acc_en) begin
                // A lane layout change makes the old lane sums meaningless, so the accumulator restarts.
                if (p_acc_clr || (p_lvl != last_lvl)) begin
                    acc_q <= p_q;
                    ovf_q <= '0;
                end else begin
                    acc_q <= sum_sel;
                    ovf_q <= ovf_q | ovf_sel;
                end
                last_lvl <= p_lvl;
            end
        end
    end

    assign bus.out_valid = vld_pipe[PIPE_STAGES-1];
    assign bus.P         = p_q;
    assign bus.acc_valid = acc_vld_q;
    assign bus.ACC       = acc_q;
    assign bus.acc_ovf   = ovf_q;
endmodule

// File: tb/tb_chop_mult_pipe_acc.sv
// Randomised bench for chop_mult_pipe_acc, scored against an arithmetic lane model with directed corner items.
module tb_chop_mult_pipe_acc;
    localparam int WIDTH = 12, LEVELS = 2, PS = 2, MODE_W = 2, NC = 1024;

    typedef struct {
        bit          v;
        logic [11:0] a, b;
        bit          sa, sb;
        int          md;
        bit          en, clr, hc, hacc;
        logic [23:0] cp, cacc;
        logic [3:0]  covf;
    } item_t;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    chop_mult_pipe_acc_if #(.WIDTH(WIDTH), .LEVELS(LEVELS), .MODE_W(MODE_W)) bus ();
    chop_mult_pipe_acc #(.WIDTH(WIDTH), .LEVELS(LEVELS), .PIPE_STAGES(PS), .MODE_W(MODE_W)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    item_t       it [NC];
    int          cyc = 0, n_chk = 0, n_pass = 0, m_last = 0;
    logic [23:0] m_p = '0, m_acc = '0;
    logic [3:0]  m_ovf = '0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, act, exp);
    endtask

    function automatic longint lane_val(logic [63:0] v, int k, int w, bit sg);
        longint x;
        x = longint'((v >> (k*w)) & ((64'd1 << w) - 64'd1));
        if (sg && x >= (longint'(1) << (w-1))) x -= longint'(1) << w;
        return x;
    endfunction

    function automatic int lvl_of(item_t t);
        return (t.md > LEVELS) ? LEVELS : t.md;
    endfunction

    function automatic logic [23:0] mprod(item_t t);
        int l, w;
        longint a, b, m;
        logic [23:0] r;
        l = lvl_of(t); w = WIDTH >> l; r = '0;
        for (int k = 0; k < (1 << l); k++) begin
            a = lane_val(64'(t.a), k, w, t.sa);
            b = lane_val(64'(t.b), k, w, t.sb);
            m = (a * b) & ((longint'(1) << (2*w)) - 1);
            r |= 24'(m) << (k*2*w);
        end
        return r;
    endfunction

    task automatic acc_step(item_t t, logic [23:0] p);
        int l, w2;
        bit sg;
        longint x, y, s, lim;
        logic [23:0] nacc;
        l = lvl_of(t); w2 = 2 * (WIDTH >> l); sg = t.sa | t.sb;
        if (t.clr || l != m_last) begin
            m_acc = p; m_ovf = '0;
        end else begin
            nacc = '0;
            lim  = longint'(1) << (w2-1);
            for (int k = 0; k < (1 << l); k++) begin
                x = lane_val(64'(m_acc), k, w2, sg);
                y = lane_val(64'(p), k, w2, sg);
                s = x + y;
                if (sg ? (s < -lim || s >= lim) : (s >= 2*lim)) m_ovf[k] = 1'b1;
                nacc |= 24'(s & ((longint'(1) << w2) - 1)) << (k*w2);
            end
            m_acc = nacc;
        end
        m_last = l;
    endtask

    function automatic item_t mk(logic [11:0] a, logic [11:0] b, bit sa, bit sb, int md, bit en, bit clr);
        item_t t;
        t = '{default: '0};
        t.v = 1'b1; t.a = a; t.b = b; t.sa = sa; t.sb = sb; t.md = md; t.en = en; t.clr = clr;
        return t;
    endfunction

    function automatic item_t idle();
        item_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic item_t rnd_item();
        item_t t;
        t = idle();
        t.v   = ($urandom_range(3) != 0);
        t.a   = ($urandom_range(4) == 0) ? 12'hFFF : 12'($urandom);
        t.b   = ($urandom_range(4) == 0) ? 12'h800 : 12'($urandom);
        t.sa  = 1'($urandom_range(1));
        t.sb  = 1'($urandom_range(1));
        t.md  = $urandom_range(3);
        t.en  = 1'($urandom_range(1));
        t.clr = ($urandom_range(7) == 0);
        return t;
    endfunction

    task automatic drive(item_t t);
        bus.in_valid = t.v;  bus.A = t.a;  bus.B = t.b;
        bus.A_sign = t.sa;   bus.B_sign = t.sb;  bus.mode = 2'(t.md);
        bus.acc_en = t.en;   bus.acc_clr = t.clr;
    endtask

    // Check this cycle's outputs, then present the next item.
    task automatic step(item_t nx);
        item_t o;
        bit ov, av;
        @(negedge clk);
        ov = 1'b0;
        if (cyc >= PS && it[cyc-PS].v) begin
            o = it[cyc-PS]; m_p = mprod(o); ov = 1'b1;
            if (o.hc) chk("p_directed", 64'(bus.P), 64'(o.cp));
        end
        chk("out_valid", 64'(bus.out_valid), 64'(ov));
        chk("P", 64'(bus.P), 64'(m_p));
        av = 1'b0;
        if (cyc >= PS+1 && it[cyc-PS-1].v && it[cyc-PS-1].en) begin
            o = it[cyc-PS-1]; acc_step(o, mprod(o)); av = 1'b1;
            if (o.hacc) begin
                chk("acc_directed", 64'(bus.ACC), 64'(o.cacc));
                chk("ovf_directed", 64'(bus.acc_ovf), 64'(o.covf));
            end
        end
        chk("acc_valid", 64'(bus.acc_valid), 64'(av));
        chk("ACC", 64'(bus.ACC), 64'(m_acc));
        chk("acc_ovf", 64'(bus.acc_ovf), 64'(m_ovf));
        drive(nx);
        it[cyc] = nx;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(idle());
        for (int j = 0; j < cyc; j++) it[j].v = 1'b0;
        m_p = '0; m_acc = '0; m_ovf = '0; m_last = 0;
        repeat (2) begin
            @(negedge clk);
            it[cyc] = idle();
            cyc++;
        end
        reset = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_P", 64'(bus.P), 64'd0);
        chk("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
        chk("rst_ACC", 64'(bus.ACC), 64'd0);
        chk("rst_acc_ovf", 64'(bus.acc_ovf), 64'd0);
    endtask

    initial begin
        item_t t;
        apply_reset();

        t = mk(12'hFFF, 12'hFFF, 0, 0, 0, 0, 0); t.hc = 1; t.cp = 24'hFFE001; step(t);
        t = mk(12'hFFF, 12'h002, 1, 1, 0, 0, 0); t.hc = 1; t.cp = 24'hFFFFFE; step(t);
        t = mk(12'hF45, 12'h13E, 1, 1, 1, 0, 0); t.hc = 1; t.cp = 24'hFF4FF6; step(t);
        t = mk(12'hFFF, 12'hFFF, 0, 0, 2, 0, 0); t.hc = 1; t.cp = 24'hC71C71; step(t);
        t = mk(12'h03F, 12'h03F, 0, 0, 1, 1, 1); t.hacc = 1; t.cacc = 24'h000F81; t.covf = 4'b0000; step(t);
        t = mk(12'h03F, 12'h03F, 0, 0, 1, 1, 0); t.hacc = 1; t.cacc = 24'h000F02; t.covf = 4'b0001; step(t);
        t = mk(12'h03F, 12'h03F, 0, 0, 1, 1, 0); t.hacc = 1; t.cacc = 24'h000E83; t.covf = 4'b0001; step(t);
        repeat (4) step(idle());

        // Items of mode 0, 1 and 2 arrive back to back, and a reset lands while later beats are still in the pipe.
        for (int i = 0; i < 4; i++) begin
            t = rnd_item(); t.v = 1'b1; t.md = i % 3; t.en = 1'b1;
            step(t);
        end
        #2;
        apply_reset();
        repeat (5) step(idle());

        for (int i = 0; i < 600; i++) step(rnd_item());
        repeat (5) step(idle());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
